// File: rtl/phy_mgmt_sequencer_if.sv
// SMI master request/response bundle between the PHY management sequencer and the MDIO engine.
// The sequencer drives requests through the master modport and the SMI engine answers through the slave modport.
interface phy_mgmt_sequencer_if;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic        write_req;
  logic [15:0] write_data;
  logic        read_req;
  logic [15:0] read_data;
  logic        data_valid;
  logic        done;

  modport master (
    output phy_addr, reg_addr, write_req, write_data, read_req,
    input  read_data, data_valid, done
  );

  modport slave (
    input  phy_addr, reg_addr, write_req, write_data, read_req,
    output read_data, data_valid, done
  );
endinterface

// File: rtl/phy_mgmt_sequencer.sv
// Writes the PHY config table after reset, then polls reg 0x11 forever and exports link/speed/duplex.
// Requests are single-cycle pulses; each waits for the SMI done or a timeout, and restarts are deferred to transaction boundaries.
module phy_mgmt_sequencer #(
  parameter logic [4:0] PHY_ADDR      = 5'd1,
  parameter int         INIT_WAIT_CYC = 500_000,
  parameter int         POLL_CYC      = 5_000_000,
  parameter int         TIMEOUT_CYC   = 100_000,
  parameter bit         ADV_1000      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_restart_i,
  phy_mgmt_sequencer_if.master smi,
  output logic                 cfg_done_o,
  output logic                 link_up_o,
  output logic [1:0]           speed_o,
  output logic                 full_duplex_o,
  output logic                 status_valid_o,
  output logic                 smi_err_o
);

  localparam int MAX_AB  = (INIT_WAIT_CYC > POLL_CYC) ? INIT_WAIT_CYC : POLL_CYC;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_CFG_REQ,
    S_CFG_WAIT,
    S_POLL_REQ,
    S_POLL_WAIT,
    S_POLL_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cap_q, cap_d;
  logic        cfg_done_q, cfg_done_d;
  logic        link_q, link_d;
  logic [1:0]  speed_q, speed_d;
  logic        fdx_q, fdx_d;
  logic        sval_q, sval_d;
  logic        err_q, err_d;

  logic        restart;
  logic        do_restart;
  logic        timeout;
  logic [15:0] rd_word;

  function automatic logic [4:0] tbl_reg(input logic [1:0] i);
    case (i)
      2'd0:    tbl_reg = 5'h04;
      2'd1:    tbl_reg = 5'h09;
      default: tbl_reg = 5'h00;
    endcase
  endfunction

  function automatic logic [15:0] tbl_dat(input logic [1:0] i);
    case (i)
      2'd0:    tbl_dat = 16'h01E1;
      2'd1:    tbl_dat = ADV_1000 ? 16'h0200 : 16'h0000;
      default: tbl_dat = 16'h1340;
    endcase
  endfunction

  assign restart = pend_q | cfg_restart_i;
  assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));
  // data_valid and done in the same cycle still yield the fresh word
  assign rd_word = smi.data_valid ? smi.read_data : cap_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CW'(1);
    pend_d     = restart;
    reg_addr_d = reg_addr_q;
    wdata_d    = wdata_q;
    cap_d      = cap_q;
    cfg_done_d = cfg_done_q;
    link_d     = link_q;
    speed_d    = speed_q;
    fdx_d      = fdx_q;
    sval_d     = sval_q;
    err_d      = err_q;
    do_restart = 1'b0;

    case (state_q)
      S_INIT_WAIT: begin
        if (restart) begin
          do_restart = 1'b1;
        end else if (cnt_q == CW'(INIT_WAIT_CYC - 1)) begin
          state_d = S_CFG_REQ;
          idx_d   = 2'd0;
        end
      end
      S_CFG_REQ: begin
        state_d = S_CFG_WAIT;
        cnt_d   = CW'(1);
      end
      S_CFG_WAIT: begin
        if (smi.done || timeout) begin
          if (!smi.done) err_d = 1'b1;
          if (restart) begin
            do_restart = 1'b1;
          end else if (idx_q == 2'd2) begin
            cfg_done_d = 1'b1;
            state_d    = S_POLL_REQ;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_CFG_REQ;
          end
        end
      end
      S_POLL_REQ: begin
        state_d = S_POLL_WAIT;
        cnt_d   = CW'(1);
      end
      S_POLL_WAIT: begin
        if (smi.data_valid) cap_d = smi.read_data;
        if (smi.done) begin
          link_d  = rd_word[10];
          speed_d = rd_word[15:14];
          fdx_d   = rd_word[13];
          sval_d  = 1'b1;
        end else if (timeout) begin
          err_d = 1'b1;
        end
        if (smi.done || timeout) begin
          if (restart) begin
            do_restart = 1'b1;
          end else begin
            state_d = S_POLL_GAP;
            cnt_d   = '0;
          end
        end
      end
      S_POLL_GAP: begin
        if (restart) begin
          do_restart = 1'b1;
        end else if (cnt_q == CW'(POLL_CYC - 1)) begin
          state_d = S_POLL_REQ;
        end
      end
      default: state_d = S_INIT_WAIT;
    endcase

    if (do_restart) begin
      state_d    = S_CFG_REQ;
      idx_d      = 2'd0;
      cfg_done_d = 1'b0;
      pend_d     = 1'b0;
    end

    // Address/payload are loaded on entry so they are valid in the request cycle itself
    if (state_d == S_CFG_REQ && state_q != S_CFG_REQ) begin
      reg_addr_d = tbl_reg(idx_d);
      wdata_d    = tbl_dat(idx_d);
    end
    if (state_d == S_POLL_REQ && state_q != S_POLL_REQ) begin
      reg_addr_d = 5'h11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT_WAIT;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      reg_addr_q <= 5'h00;
      wdata_q    <= 16'h0000;
      cap_q      <= 16'h0000;
      cfg_done_q <= 1'b0;
      link_q     <= 1'b0;
      speed_q    <= 2'b00;
      fdx_q      <= 1'b0;
      sval_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      reg_addr_q <= reg_addr_d;
      wdata_q    <= wdata_d;
      cap_q      <= cap_d;
      cfg_done_q <= cfg_done_d;
      link_q     <= link_d;
      speed_q    <= speed_d;
      fdx_q      <= fdx_d;
      sval_q     <= sval_d;
      err_q      <= err_d;
    end
  end

  assign smi.phy_addr   = PHY_ADDR;
  assign smi.reg_addr   = reg_addr_q;
  assign smi.write_data = wdata_q;
  assign smi.write_req  = (state_q == S_CFG_REQ);
  assign smi.read_req   = (state_q == S_POLL_REQ);

  assign cfg_done_o     = cfg_done_q;
  assign link_up_o      = link_q;
  assign speed_o        = speed_q;
  assign full_duplex_o  = fdx_q;
  assign status_valid_o = sval_q;
  assign smi_err_o      = err_q;

endmodule

// File: tb/tb_phy_mgmt_sequencer.sv
// Bench for phy_mgmt_sequencer: SMI responder model answering 40 cycles after each request, plus a
// scoreboard of expected writes and expected poll results.
module tb_phy_mgmt_sequencer;
  localparam int INIT_W  = 20;
  localparam int POLL_W  = 50;
  localparam int TOUT_W  = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_restart = 1'b0;
  logic       cfg_done, link_up, full_duplex, status_valid, smi_err;
  logic [1:0] speed;

  phy_mgmt_sequencer_if smi ();

  phy_mgmt_sequencer #(
    .PHY_ADDR(5'd1), .INIT_WAIT_CYC(INIT_W), .POLL_CYC(POLL_W),
    .TIMEOUT_CYC(TOUT_W), .ADV_1000(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_restart_i(cfg_restart), .smi(smi),
    .cfg_done_o(cfg_done), .link_up_o(link_up), .speed_o(speed),
    .full_duplex_o(full_duplex), .status_valid_o(status_valid), .smi_err_o(smi_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  logic [20:0] exp_wr[$];
  logic [3:0]  exp_stat[$];
  logic [15:0] rd_q[$];

  task automatic push_entry(input int i);
    case (i)
      0: exp_wr.push_back({5'h04, 16'h01E1});
      1: exp_wr.push_back({5'h09, 16'h0200});
      default: exp_wr.push_back({5'h00, 16'h1340});
    endcase
  endtask

  // SMI responder
  int          m_cnt = 0;
  int          m_wr = 0;
  int          withhold_idx = -1;
  bit          m_is_rd = 1'b0;
  bit          m_drop = 1'b0;
  bit          spur = 1'b0;
  logic [15:0] d;

  initial begin
    smi.done = 1'b0; smi.data_valid = 1'b0; smi.read_data = 16'h0;
    forever begin
      @(negedge clk);
      smi.done = 1'b0;
      smi.data_valid = 1'b0;
      if (!rst_n) begin
        m_cnt = 0; m_wr = 0;
        exp_stat.delete();
      end else begin
        if (smi.write_req || smi.read_req) begin
          m_cnt   = 40;
          m_is_rd = smi.read_req;
          m_drop  = smi.write_req && (m_wr == withhold_idx);
          if (smi.write_req) m_wr++;
        end else if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 1 && m_is_rd) begin
            d = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0000;
            smi.data_valid = 1'b1;
            smi.read_data  = d;
            exp_stat.push_back({d[10], d[15:14], d[13]});
          end
          if (m_cnt == 0 && !m_drop) smi.done = 1'b1;
        end
        if (spur) begin
          smi.done = 1'b1;
          spur = 1'b0;
        end
      end
    end
  end

  // Monitor / scoreboard
  int          wr_cnt = 0, rd_cnt = 0, stat_cnt = 0;
  bit          rd_out = 1'b0, prev_req = 1'b0;
  logic [20:0] ew;
  logic [3:0]  es;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        rd_out = 1'b0; prev_req = 1'b0;
      end else begin
        if (smi.done && rd_out) begin
          rd_out = 1'b0;
          if (exp_stat.size() == 0) check("stat_exp_avail", 0, 1);
          else begin
            es = exp_stat.pop_front();
            check("link_up", link_up, es[3]);
            check("speed", speed, es[2:1]);
            check("full_duplex", full_duplex, es[0]);
            check("status_valid", status_valid, 1);
          end
          stat_cnt++;
        end
        if (smi.write_req || smi.read_req) begin
          check("req_excl_nobk2bk", {smi.write_req && smi.read_req, prev_req}, 0);
          check("phy_addr", smi.phy_addr, 5'd1);
        end
        if (smi.write_req) begin
          wr_cnt++;
          check("cfg_done_low_in_write", cfg_done, 0);
          if (exp_wr.size() == 0) check("wr_expected", 0, 1);
          else begin
            ew = exp_wr.pop_front();
            check("wr_reg", smi.reg_addr, ew[20:16]);
            check("wr_data", smi.write_data, ew[15:0]);
          end
        end
        if (smi.read_req) begin
          rd_cnt++;
          rd_out = 1'b1;
          check("rd_reg", smi.reg_addr, 5'h11);
          check("cfg_done_at_poll", cfg_done, 1);
        end
        prev_req = smi.write_req || smi.read_req;
      end
    end
  end

  // which: 0 wr_cnt>=tgt, 1 rd_cnt>=tgt, 2 stat_cnt>=tgt, 3 smi_err set
  task automatic wait_cnt(input int which, input int tgt, input int budget,
                          input string tag, output int n);
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(posedge clk);
      #2;
      n++;
      case (which)
        0: hit = (wr_cnt >= tgt);
        1: hit = (rd_cnt >= tgt);
        2: hit = (stat_cnt >= tgt);
        default: hit = (smi_err == 1'b1);
      endcase
    end
    if (!hit) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n, w0, r0, s0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_phy_addr", smi.phy_addr, 5'd1);
    check("rst_reg_addr", smi.reg_addr, 0);
    check("rst_write_data", smi.write_data, 0);
    check("rst_flags", {smi.write_req, smi.read_req, cfg_done, link_up, speed,
                        full_duplex, status_valid, smi_err}, 0);

    // 1: config table after reset
    for (int i = 0; i < 3; i++) push_entry(i);
    rd_q.push_back(16'hA400);
    rd_q.push_back(16'h4000);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cnt(0, 1, 100, "first_wr", n);
    check("first_wr_cycle", n, INIT_W);
    wait_cnt(1, 1, 400, "first_rd", n);

    // 2: first poll, spurious done in the gap, gap length
    wait_cnt(2, 1, 100, "poll1", n);
    spur = 1'b1;
    wait_cnt(1, 2, 200, "poll2_req", n);
    check("poll_gap_cycles", n, POLL_W);

    // 3: second poll result (checked by scoreboard)
    wait_cnt(2, 2, 100, "poll2", n);

    // 6: reset during POLL_WAIT
    wait_cnt(1, 3, 200, "poll3_req", n);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {smi.write_req, smi.read_req, cfg_done, link_up, speed,
                           full_duplex, status_valid, smi_err}, 0);
    check("midrst_reg_addr", smi.reg_addr, 0);
    repeat (2) @(posedge clk);

    // 4: withhold done on the 2nd config write
    withhold_idx = 1;
    for (int i = 0; i < 3; i++) push_entry(i);
    rd_q.push_back(16'h6400);
    w0 = wr_cnt;
    s0 = stat_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cnt(0, w0 + 1, 100, "rst_first_wr", n);
    check("rst_first_wr_cycle", n, INIT_W);
    wait_cnt(0, w0 + 2, 100, "wr2", n);
    wait_cnt(3, 0, 400, "smi_err", n);
    check("timeout_cycles", n, TOUT_W);
    check("cfg_done_after_timeout", cfg_done, 0);
    wait_cnt(0, w0 + 3, 5, "wr3_after_timeout", n);
    wait_cnt(2, s0 + 1, 400, "poll_after_err", n);
    check("smi_err_sticky", smi_err, 1);
    withhold_idx = -1;

    // 5: restart from POLL_GAP, then again mid-write of entry 1
    repeat (5) @(posedge clk);
    #2;
    w0 = wr_cnt;
    r0 = rd_cnt;
    push_entry(0);
    push_entry(1);
    cfg_restart = 1'b1;
    @(posedge clk);
    #2;
    cfg_restart = 1'b0;
    @(posedge clk);
    #2;
    check("restart_cfg_done_cleared", cfg_done, 0);
    check("restart_status_kept", {status_valid, link_up, speed, full_duplex}, 5'b1_1_01_1);
    wait_cnt(0, w0 + 2, 100, "restart_wr1", n);
    for (int i = 0; i < 3; i++) push_entry(i);
    repeat (10) @(posedge clk);
    #2;
    cfg_restart = 1'b1;
    @(posedge clk);
    #2;
    cfg_restart = 1'b0;
    wait_cnt(0, w0 + 3, 100, "restart_wr0_again", n);
    check("restart_deferred_cycles", n, 30);
    check("cfg_done_during_restart", cfg_done, 0);
    wait_cnt(1, r0 + 1, 400, "restart_poll", n);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("smi_err_still_set", smi_err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
